// File: rtl/alu_4bit_pkg.sv
// Shared constants for the 4-bit add/subtract ALU.
package alu_4bit_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   ALU_W  = 4;

endpackage : alu_4bit_pkg

// File: rtl/alu_4bit_if.sv
// Operand/result bundle for alu_4bit: the driver is the master, the ALU is the slave.
interface alu_4bit_if;
  import alu_4bit_pkg::*;

  logic [ALU_W-1:0] a;
  logic [ALU_W-1:0] b;
  logic             operator;
  logic [ALU_W-1:0] s;
  logic             overflow;

  modport master (
    output a,
    output b,
    output operator,
    input  s,
    input  overflow
  );

  modport slave (
    input  a,
    input  b,
    input  operator,
    output s,
    output overflow
  );

endinterface : alu_4bit_if

// File: rtl/alu_4bit_full_adder.sv
// One-bit full adder; the ALU chains these into a ripple-carry adder.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule : full_adder

// File: rtl/alu_4bit.sv
// Registered 4-bit add/subtract ALU with signed overflow flag, one-cycle latency.
module alu_4bit
  import alu_4bit_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_4bit_if.slave  bus
);

  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum;
  logic             ov_d;
  logic [WIDTH-1:0] s_q;
  logic             ov_q;

  // Subtraction is a + ~b + 1: operator both inverts b and supplies the +1 as carry-in.
  assign b_x      = bus.b ^ {WIDTH{bus.operator == OP_SUB}};
  assign carry[0] = (bus.operator == OP_SUB);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    full_adder u_fa (
      .x    (bus.a[gi]),
      .y    (b_x[gi]),
      .cin  (carry[gi]),
      .sum  (sum[gi]),
      .cout (carry[gi+1])
    );
  end

  assign ov_d = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      s_q  <= sum;
      ov_q <= ov_d;
    end
  end

  assign bus.s        = s_q;
  assign bus.overflow = ov_q;

endmodule : alu_4bit

// File: tb/tb_alu_4bit.sv
// Bench for alu_4bit: signed-arithmetic reference model checked every cycle, plus literal checks.
module tb_alu_4bit;
  import alu_4bit_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  logic [3:0] m_s  = 4'h0;
  logic       m_ov = 1'b0;

  alu_4bit_if alu_if ();

  alu_4bit u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (alu_if)
  );

  always #5 clk = ~clk;

  // Reference: interpret operands as signed integers, do the math, then wrap to 4 bits.
  function automatic void ref_alu(input logic [3:0] a, input logic [3:0] b, input logic op,
                                  output logic [3:0] s, output logic ov);
    int sa, sb, r;
    sa = (a >= 4'd8) ? int'(a) - 16 : int'(a);
    sb = (b >= 4'd8) ? int'(b) - 16 : int'(b);
    r  = (op == OP_SUB) ? sa - sb : sa + sb;
    s  = r[3:0];
    ov = (r > 7) || (r < -8);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_s  = 4'h0;
      m_ov = 1'b0;
    end else begin
      ref_alu(alu_if.a, alu_if.b, alu_if.operator, m_s, m_ov);
    end
  end

  always @(negedge clk) begin
    cyc++;
    $display("cyc %0d rst_n=%b a=%h b=%h op=%b -> s=%h ov=%b (model s=%h ov=%b)",
             cyc, rst_n, alu_if.a, alu_if.b, alu_if.operator,
             alu_if.s, alu_if.overflow, m_s, m_ov);
    chk("cmp_s", int'(alu_if.s), int'(m_s));
    chk("cmp_ov", int'(alu_if.overflow), int'(m_ov));
  end

  // Drive one operand set, wait one edge, check DUT and model against literals.
  task automatic apply(input logic [3:0] a, input logic [3:0] b, input logic op,
                       input logic [3:0] exp_s, input logic exp_ov, input string name);
    @(negedge clk);
    alu_if.a        = a;
    alu_if.b        = b;
    alu_if.operator = op;
    @(posedge clk);
    #1;
    chk({name, "_s"}, int'(alu_if.s), int'(exp_s));
    chk({name, "_ov"}, int'(alu_if.overflow), int'(exp_ov));
    chk({name, "_model_s"}, int'(m_s), int'(exp_s));
    chk({name, "_model_ov"}, int'(m_ov), int'(exp_ov));
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic op);
    @(negedge clk);
    alu_if.a        = a;
    alu_if.b        = b;
    alu_if.operator = op;
  endtask

  initial begin
    alu_if.a        = 4'h5;
    alu_if.b        = 4'h3;
    alu_if.operator = OP_ADD;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_imm_s", int'(alu_if.s), 0);
    chk("rst_imm_ov", int'(alu_if.overflow), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold_s", int'(alu_if.s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_rel_s", int'(alu_if.s), 8);
    chk("rst_rel_ov", int'(alu_if.overflow), 1);

    apply(4'h3, 4'h4, OP_ADD, 4'h7, 1'b0, "add_3_4");
    apply(4'h7, 4'h1, OP_ADD, 4'h8, 1'b1, "add_7_1");
    apply(4'hF, 4'h1, OP_ADD, 4'h0, 1'b0, "add_f_1");
    apply(4'h8, 4'h8, OP_ADD, 4'h0, 1'b1, "add_8_8");
    apply(4'h5, 4'h3, OP_SUB, 4'h2, 1'b0, "sub_5_3");
    apply(4'h0, 4'h1, OP_SUB, 4'hF, 1'b0, "sub_0_1");
    apply(4'h8, 4'h1, OP_SUB, 4'h7, 1'b1, "sub_8_1");
    apply(4'h8, 4'h8, OP_SUB, 4'h0, 1'b0, "sub_8_8");

    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) apply(4'h6, 4'h2, OP_ADD, 4'h8, 1'b1, "b2b_add");
      else            apply(4'h6, 4'h2, OP_SUB, 4'h4, 1'b0, "b2b_sub");
    end

    for (int op = 0; op < 2; op++)
      for (int a = 0; a < 16; a++)
        for (int b = 0; b < 16; b++)
          drive(4'(a), 4'(b), op[0]);

    for (int i = 0; i < 200; i++)
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));

    apply(4'h3, 4'h4, OP_ADD, 4'h7, 1'b0, "pre_mid_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_s", int'(alu_if.s), 0);
    chk("mid_rst_ov", int'(alu_if.overflow), 0);
    drive(4'h7, 4'h1, OP_ADD);
    @(posedge clk);
    #1;
    chk("mid_rst_hold_s", int'(alu_if.s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_resume_s", int'(alu_if.s), 8);
    chk("mid_rst_resume_ov", int'(alu_if.overflow), 1);

    for (int i = 0; i < 50; i++)
      drive(4'($urandom_range(15)), 4'($urandom_range(15)), 1'($urandom_range(1)));
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_4bit

// File: doc/alu_4bit.md
ALU_4BIT -- requirements
Module: alu_4bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the operand/result width; only 4 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port a, input, 4 bits: operand A, two's-complement or unsigned.
REQ-005 The block SHALL have port b, input, 4 bits: operand B.
REQ-006 The block SHALL have port operator, input, 1 bit: 0 = add (a+b), 1 = subtract (a-b).
REQ-007 The block SHALL have port s, output, 4 bits: registered result.
REQ-008 The block SHALL have port overflow, output, 1 bit: registered signed two's-complement overflow flag for the result in s.

Function
REQ-009 The add path SHALL compute s = (a + b) mod 16.
REQ-010 The subtract path SHALL compute s = (a + ~b + 1) mod 16, with the +1 injected as carry-in of bit 0.
REQ-011 Both operations SHALL use the same ripple-carry chain; b SHALL be XORed bitwise with operator, and operator SHALL drive carry-in.
REQ-012 overflow SHALL be carry-into-MSB XOR carry-out-of-MSB, equivalently set when the operand signs (after B inversion) match and the result sign differs.
REQ-013 Carry-out of bit 3 SHALL be computed internally but SHALL NOT be a port; unsigned borrow/carry is not reported.
REQ-014 Latency SHALL be exactly 1 clock: inputs sampled at rising edge N appear on s/overflow after edge N.
REQ-015 New operands SHALL be accepted every cycle (throughput 1/cycle), with no handshake and no stall.
REQ-016 Wrap-around SHALL be silent: 0xF+0x1 -> s=0x0, overflow=0; 0x0-0x1 -> s=0xF, overflow=0.
REQ-017 Boundary cases SHALL set overflow: 0x7+0x1 -> 0x8 with overflow=1; 0x8-0x1 -> 0x7 with overflow=1; 0x8+0x8 -> 0x0 with overflow=1.
REQ-018 Self-subtraction (a==b, operator=1) SHALL give s=0x0 with overflow=0, including a=b=0x8.
REQ-019 A change of operator alone between cycles SHALL take effect at the next edge, with no hold-over state.

Reset
REQ-020 While rst_n=0, s SHALL be 0x0 and overflow SHALL be 0, taking effect immediately without waiting for clk.
REQ-021 An rst_n assertion mid-stream SHALL discard the pending result; the first valid result SHALL appear one edge after the first rising clk with rst_n=1.
REQ-022 No state other than the s and overflow registers SHALL exist.

Structure
REQ-023 Package alu_4bit_pkg SHALL hold constants OP_ADD=1'b0, OP_SUB=1'b1, and ALU_W=4.
REQ-024 A sub-module full_adder (inputs x, y, cin; outputs sum, cout) SHALL be instantiated 4 times in a generate loop to form the chain.
REQ-025 The top level SHALL contain the B-inversion XOR, the overflow XOR, and the output register with asynchronous reset.

Verification
REQ-026 Reset: rst_n=0 with a=0x5, b=0x3 -> s=0x0, overflow=0 immediately; after release, one edge later s=0x8.
REQ-027 Add: operator=0, a=0x3, b=0x4 -> s=0x7, ov=0; a=0x7, b=0x1 -> s=0x8, ov=1; a=0xF, b=0x1 -> s=0x0, ov=0.
REQ-028 Subtract: operator=1, a=0x5, b=0x3 -> s=0x2, ov=0; a=0x0, b=0x1 -> s=0xF, ov=0; a=0x8, b=0x1 -> s=0x7, ov=1.
REQ-029 Back-to-back: alternate operator every cycle with a=0x6, b=0x2 -> s sequence 0x8(ov=1), 0x4(ov=0), ..., each one cycle late.
REQ-030 Exhaustive: all 256 (a,b) pairs x both operators, one per cycle, compared against reference model mod 16 and signed-overflow rule.
REQ-031 Mid-run reset: assert rst_n asynchronously between edges -> outputs clear at once, and the stream resumes correctly after release.
